// File: rtl/piso_serializer_if.sv
// Load and serial-stream handshake bundle for the PISO serializer.
// The master side supplies words and consumes bits; the slave side is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 8
);
    logic             load_valid;
    logic [WIDTH-1:0] load_data;
    logic             load_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_last;
    logic             ser_ready;

    modport master (
        output load_valid,
        output load_data,
        output ser_ready,
        input  load_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_last
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  ser_ready,
        output load_ready,
        output ser_out,
        output ser_valid,
        output ser_last
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word holding register so that
// consecutive words stream out with no idle cycles between them.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input logic               clk,
    input logic               rst,
    piso_serializer_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SH_ZERO  = {WIDTH{1'b0}};

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] sh_r;
    logic [WIDTH-1:0] sh_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [WIDTH-1:0] hold_r;
    logic [WIDTH-1:0] hold_nxt_s;
    logic             hold_full_r;
    logic             hold_full_nxt_s;

    logic             load_fire_s;
    logic             xfer_s;
    logic             last_xfer_s;
    logic             ser_valid_s;
    logic             ser_out_s;
    logic             ser_last_s;
    logic             load_ready_s;

    // Move every bit one place toward the output end, filling with zero.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    function automatic logic out_bit(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return v[WIDTH-1];
        end else begin
            return v[0];
        end
    endfunction

    assign load_fire_s = bus.load_valid && load_ready_s;
    assign xfer_s      = ser_valid_s && bus.ser_ready;
    assign last_xfer_s = xfer_s && ser_last_s;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: leave SHIFT only when the last bit goes with nothing queued behind it.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (load_fire_s) begin
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (last_xfer_s && !hold_full_r && !load_fire_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state only; load_ready also gates on rst.
    always_comb begin
        ser_valid_s  = (state_r == ST_SHIFT);
        ser_out_s    = 1'b0;
        ser_last_s   = 1'b0;
        load_ready_s = !hold_full_r && !rst;
        if (ser_valid_s) begin
            ser_out_s  = out_bit(sh_r);
            ser_last_s = (cnt_r == CNT_LAST);
        end else begin
            ser_out_s  = 1'b0;
            ser_last_s = 1'b0;
        end
    end

    assign bus.ser_valid  = ser_valid_s;
    assign bus.ser_out    = ser_out_s;
    assign bus.ser_last   = ser_last_s;
    assign bus.load_ready = load_ready_s;

    // Datapath next values: shifter, bit counter and holding register.
    always_comb begin
        sh_nxt_s        = sh_r;
        cnt_nxt_s       = cnt_r;
        hold_nxt_s      = hold_r;
        hold_full_nxt_s = hold_full_r;
        case (state_r)
            ST_IDLE: begin
                if (load_fire_s) begin
                    sh_nxt_s  = bus.load_data;
                    cnt_nxt_s = CNT_ZERO;
                end else begin
                    sh_nxt_s  = sh_r;
                    cnt_nxt_s = cnt_r;
                end
            end
            ST_SHIFT: begin
                if (last_xfer_s) begin
                    // A held word takes precedence; load_ready is low whenever hold is full.
                    if (hold_full_r) begin
                        sh_nxt_s        = hold_r;
                        cnt_nxt_s       = CNT_ZERO;
                        hold_full_nxt_s = 1'b0;
                    end else if (load_fire_s) begin
                        sh_nxt_s  = bus.load_data;
                        cnt_nxt_s = CNT_ZERO;
                    end else begin
                        sh_nxt_s  = SH_ZERO;
                        cnt_nxt_s = CNT_ZERO;
                    end
                end else begin
                    if (xfer_s) begin
                        sh_nxt_s  = shift_toward_out(sh_r);
                        cnt_nxt_s = cnt_r + CNT_ONE;
                    end else begin
                        sh_nxt_s  = sh_r;
                        cnt_nxt_s = cnt_r;
                    end
                    if (load_fire_s) begin
                        hold_nxt_s      = bus.load_data;
                        hold_full_nxt_s = 1'b1;
                    end else begin
                        hold_nxt_s      = hold_r;
                        hold_full_nxt_s = hold_full_r;
                    end
                end
            end
            default: begin
                sh_nxt_s        = SH_ZERO;
                cnt_nxt_s       = CNT_ZERO;
                hold_nxt_s      = SH_ZERO;
                hold_full_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset discards both the in-flight and the held word.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_r        <= SH_ZERO;
            cnt_r       <= CNT_ZERO;
            hold_r      <= SH_ZERO;
            hold_full_r <= 1'b0;
        end else begin
            sh_r        <= sh_nxt_s;
            cnt_r       <= cnt_nxt_s;
            hold_r      <= hold_nxt_s;
            hold_full_r <= hold_full_nxt_s;
        end
    end
endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed cycle checks plus a
// scoreboard of expected bits pushed on every load and popped on every transfer.
module tb_piso_serializer;
    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [1:0] q_m[$];
    logic [1:0] q_l[$];
    logic [1:0] ent_m;
    logic [1:0] ent_l;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) bus_m ();
    piso_serializer_if #(.WIDTH(8)) bus_l ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .rst(rst), .bus(bus_m.slave));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .rst(rst), .bus(bus_l.slave));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] exp_entry(input logic [7:0] d, input int i, input bit msb);
        return {(i == 7), (msb ? d[7-i] : d[i])};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboards sample at negedge, where inputs equal what the next posedge sees.
    always @(negedge clk) begin
        if (rst) begin
            q_m.delete();
        end else begin
            if (bus_m.ser_valid && bus_m.ser_ready) begin
                check_eq("sb_m_expected", 32'(q_m.size() != 0), 32'd1);
                if (q_m.size() != 0) begin
                    ent_m = q_m.pop_front();
                    check_eq("sb_m_bit", bus_m.ser_out, ent_m[0]);
                    check_eq("sb_m_last", bus_m.ser_last, ent_m[1]);
                end
            end
            if (bus_m.load_valid && bus_m.load_ready) begin
                for (int i = 0; i < 8; i++) q_m.push_back(exp_entry(bus_m.load_data, i, 1'b1));
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            q_l.delete();
        end else begin
            if (bus_l.ser_valid && bus_l.ser_ready) begin
                check_eq("sb_l_expected", 32'(q_l.size() != 0), 32'd1);
                if (q_l.size() != 0) begin
                    ent_l = q_l.pop_front();
                    check_eq("sb_l_bit", bus_l.ser_out, ent_l[0]);
                    check_eq("sb_l_last", bus_l.ser_last, ent_l[1]);
                end
            end
            if (bus_l.load_valid && bus_l.load_ready) begin
                for (int i = 0; i < 8; i++) q_l.push_back(exp_entry(bus_l.load_data, i, 1'b0));
            end
        end
    end

    initial begin
        logic [15:0] stream;
        logic [7:0]  w;
        int          e;
        rst = 1'b1;
        bus_m.load_valid = 1'b0; bus_m.load_data = 8'h00; bus_m.ser_ready = 1'b1;
        bus_l.load_valid = 1'b0; bus_l.load_data = 8'h00; bus_l.ser_ready = 1'b1;
        tick();
        tick();
        check_eq("rst_valid", bus_m.ser_valid, 1'b0);
        check_eq("rst_out", bus_m.ser_out, 1'b0);
        check_eq("rst_last", bus_m.ser_last, 1'b0);
        check_eq("rst_load_ready", bus_m.load_ready, 1'b0);
        rst = 1'b0;
        #1;
        check_eq("post_rst_load_ready", bus_m.load_ready, 1'b1);

        // Single word 0xA5.
        tick();
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'hA5;
        tick();
        bus_m.load_valid = 1'b0;
        w = 8'hA5;
        for (int c = 0; c < 8; c++) begin
            check_eq("single_valid", bus_m.ser_valid, 1'b1);
            check_eq("single_bit", bus_m.ser_out, w[7-c]);
            check_eq("single_last", bus_m.ser_last, (c == 7));
            tick();
        end
        check_eq("single_done_valid", bus_m.ser_valid, 1'b0);

        // Back-to-back 0xA5 then 0x3C through the holding register.
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'hA5;
        tick();
        check_eq("b2b_ready_c0", bus_m.load_ready, 1'b1);
        bus_m.load_data = 8'h3C;
        stream = 16'hA53C;
        for (int c = 0; c < 16; c++) begin
            check_eq("b2b_valid", bus_m.ser_valid, 1'b1);
            check_eq("b2b_bit", bus_m.ser_out, stream[15-c]);
            check_eq("b2b_last", bus_m.ser_last, (c == 7 || c == 15));
            if (c >= 1) check_eq("b2b_load_ready", bus_m.load_ready, (c >= 8));
            tick();
            bus_m.load_valid = 1'b0;
        end
        check_eq("b2b_done_valid", bus_m.ser_valid, 1'b0);

        // Load 0xF0 on the same edge as the last bit of 0x81.
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'h81;
        tick();
        bus_m.load_valid = 1'b0;
        stream = 16'h81F0;
        for (int c = 0; c < 16; c++) begin
            check_eq("same_valid", bus_m.ser_valid, 1'b1);
            check_eq("same_bit", bus_m.ser_out, stream[15-c]);
            check_eq("same_last", bus_m.ser_last, (c == 7 || c == 15));
            if (c == 7) begin
                check_eq("same_load_ready", bus_m.load_ready, 1'b1);
                bus_m.load_valid = 1'b1; bus_m.load_data = 8'hF0;
            end else begin
                bus_m.load_valid = 1'b0;
            end
            tick();
        end
        check_eq("same_done_valid", bus_m.ser_valid, 1'b0);

        // Backpressure: ser_ready low for three cycles while bit index 2 is shown.
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'hC3;
        tick();
        bus_m.load_valid = 1'b0;
        w = 8'hC3;
        for (int c = 0; c < 11; c++) begin
            e = (c < 2) ? c : ((c <= 5) ? 2 : c - 3);
            check_eq("bp_valid", bus_m.ser_valid, 1'b1);
            check_eq("bp_bit", bus_m.ser_out, w[7-e]);
            check_eq("bp_last", bus_m.ser_last, (e == 7));
            bus_m.ser_ready = (c >= 2 && c <= 4) ? 1'b0 : 1'b1;
            tick();
        end
        bus_m.ser_ready = 1'b1;
        check_eq("bp_done_valid", bus_m.ser_valid, 1'b0);

        // LSB-first instance sends 0x01 as 1 then seven zeros.
        bus_l.load_valid = 1'b1; bus_l.load_data = 8'h01;
        tick();
        bus_l.load_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            check_eq("lsb_valid", bus_l.ser_valid, 1'b1);
            check_eq("lsb_bit", bus_l.ser_out, (c == 0));
            check_eq("lsb_last", bus_l.ser_last, (c == 7));
            tick();
        end
        check_eq("lsb_done_valid", bus_l.ser_valid, 1'b0);

        // Reset at bit 4 of 0xFF with 0x55 held; 0x55 must never appear.
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'hFF;
        tick();
        bus_m.load_data = 8'h55;
        tick();
        bus_m.load_valid = 1'b0;
        check_eq("rst_mid_hold_full", bus_m.load_ready, 1'b0);
        for (int c = 1; c < 5; c++) begin
            check_eq("rst_mid_bit", bus_m.ser_out, 1'b1);
            if (c < 4) tick();
        end
        rst = 1'b1;
        #1;
        check_eq("rst_mid_load_ready_low", bus_m.load_ready, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_eq("rst_mid_valid", bus_m.ser_valid, 1'b0);
        check_eq("rst_mid_out", bus_m.ser_out, 1'b0);
        check_eq("rst_mid_last", bus_m.ser_last, 1'b0);
        check_eq("rst_mid_load_ready", bus_m.load_ready, 1'b1);
        for (int c = 0; c < 12; c++) begin
            tick();
            check_eq("rst_mid_idle", bus_m.ser_valid, 1'b0);
        end

        // A fresh word after reset must stream cleanly.
        bus_m.load_valid = 1'b1; bus_m.load_data = 8'h96;
        tick();
        bus_m.load_valid = 1'b0;
        w = 8'h96;
        for (int c = 0; c < 8; c++) begin
            check_eq("post_rst_bit", bus_m.ser_out, w[7-c]);
            check_eq("post_rst_last", bus_m.ser_last, (c == 7));
            tick();
        end
        tick();
        check_eq("sb_m_drained", q_m.size(), 32'd0);
        check_eq("sb_l_drained", q_l.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
